lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Hardware sequencer for the character LCD that sits between the core's memory-mapped LCD output word (`o_io_lcd`, written by software stores) and the HD44780-style LCD pins. Software writes a byte, an RS bit and a request toggle into the LCD register. This block detects the toggle, latches the byte and generates the setup / enable-pulse / hold / execution-delay timing in hardware. Software no longer busy-waits on instruction counts. A one-deep pending slot absorbs one back-to-back request; a sticky flag records any request lost beyond that.

## Interface
Parameters:
- `T_SETUP`, default 4: cycles of RS/data setup before EN rises (≥1).
- `T_PULSE`, default 25: cycles EN is held high (≥1).
- `T_HOLD`, default 4: cycles data/RS are held after EN falls (≥1).
- `T_EXEC`, default 2000: execution-delay cycles for normal commands and data (≥1).
- `T_EXEC_LONG`, default 82000: execution-delay cycles for clear/home commands (≥1).
- `CNT_W`, default 17: phase counter width; must hold max(all T_*) − 1.

Ports:
- `i_clk` in 1: the single clock.
- `i_reset` in 1: synchronous, active-low reset.
- `i_io_lcd` in 32: LCD register word. Bit 31 = display power, bit 9 = RS, bit 8 = request toggle, bits 7:0 = byte. Other bits are ignored.
- `o_lcd_data` out 8: LCD data bus.
- `o_lcd_rs` out 1: register select (0 = command, 1 = data).
- `o_lcd_rw` out 1: tied to 0; write-only.
- `o_lcd_en` out 1: enable strobe.
- `o_lcd_on` out 1: display power, equal to `i_io_lcd[31]` delayed by one cycle.
- `o_busy` out 1: transaction in progress or pending.
- `o_ack` out 1: toggles once per completed transaction.
- `o_ovf` out 1: sticky; a request was dropped.

## Operation
- Request detect: `req_prev` is a register that tracks `i_io_lcd[8]`. A request exists in any cycle where `i_io_lcd[8] != req_prev`. `{RS, byte}` is captured in that same cycle.
- FSM states: IDLE, SETUP, PULSE, HOLD, EXEC. One down-counter is loaded on each state entry.
- IDLE: on a request, latch `{rs, data}` and go to SETUP.
- SETUP: drive `o_lcd_data`/`o_lcd_rs` from the latch, EN = 0, for T_SETUP cycles, then go to PULSE.
- PULSE: EN = 1 for T_PULSE cycles, then go to HOLD.
- HOLD: EN = 0, data/RS unchanged, for T_HOLD cycles, then go to EXEC.
- EXEC: wait the execution delay, then complete.
  - The delay is T_EXEC_LONG when the latched RS = 0 and the byte is 0x01, 0x02 or 0x03.
  - Otherwise the delay is T_EXEC.
  - On completion, toggle `o_ack`. If the pending slot is valid, move it into the latch, clear the slot and go straight to SETUP. Otherwise go to IDLE.
- Request while not in IDLE:
  - If the pending slot is empty, capture `{rs, byte}` into it.
  - If the slot is full, discard the request and set `o_ovf`.
- Request in the same cycle EXEC completes with the slot full: the slot entry proceeds and the new request is dropped with `o_ovf` set. With the slot empty, the new request goes into the slot.
- `o_lcd_data`/`o_lcd_rs` keep their last latched values in IDLE.
- `o_lcd_on` is independent of the FSM.

## Timing
- Reset values, taking effect on the first edge with `i_reset` = 0:
  - All outputs are 0; the FSM is in IDLE.
  - `req_prev` is loaded from `i_io_lcd[8]`, so no spurious request appears after reset.
  - The pending slot is cleared.
- Reset mid-transaction aborts immediately: EN drops and the pending entry is lost.
- Request seen in cycle N from IDLE:
  - SETUP is entered at edge N+1.
  - EN is high for exactly T_PULSE cycles, starting T_SETUP cycles after SETUP entry.
  - `o_ack` toggles, and the FSM leaves EXEC, T_SETUP+T_PULSE+T_HOLD+Texec cycles after SETUP entry.
- `o_busy` is high from edge N+1 until `o_ack` toggles with nothing pending. It stays continuously high across chained pending transactions.
- Chained transactions have no IDLE cycle between them: the next SETUP begins on the edge that toggles `o_ack`.
- `o_lcd_on` follows `i_io_lcd[31]` with a latency of 1 cycle.

## Test plan
Run with T_SETUP=2, T_PULSE=3, T_HOLD=2, T_EXEC=5, T_EXEC_LONG=20.
- Reset with `i_io_lcd[8]`=1 held, then release → no transaction; all outputs stay 0.
- Toggle bit 8 with RS=1 and byte 0x41 → data=0x41, rs=1. EN is high for 3 cycles starting 2 cycles after SETUP entry. `o_ack` flips 12 cycles after SETUP entry, then `o_busy` falls.
- Command 0x01 (RS=0) → EXEC lasts 20 cycles; `o_ack` flips 27 cycles after SETUP entry.
- Two toggles 1 cycle apart (0x30, then 0x31) → two back-to-back transactions, no IDLE gap, `o_ack` toggles twice, `o_ovf`=0.
- Three rapid toggles (0x30, 0x31, 0x32) → only 0x30 and 0x31 appear on the bus; `o_ovf`=1 and stays 1 until reset.
- Assert reset during PULSE → EN goes to 0 at the next edge; busy, ack and ovf are all 0 afterward.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write sequencer: detects a request toggle in the LCD register word and
// generates setup / enable-pulse / hold / execution-delay timing, with a one-deep pending slot.
module lcd_ctrl #(
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_PULSE     = 25,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 82000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_ack,
  output logic        o_ovf
);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StExec} state_e;

  localparam logic [CNT_W-1:0] LdSetup    = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LdPulse    = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LdHold     = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LdExec     = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LdExecLong = CNT_W'(T_EXEC_LONG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       cur_q, cur_d;    // {rs, data} on the bus
  logic [8:0]       pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ack_q, ack_d;
  logic             ovf_q, ovf_d;
  logic             req_prev_q;
  logic             on_q;
  logic             req;
  logic             cnt_zero;
  logic             long_cmd;
  logic [8:0]       req_word;
  logic             unused_bits;

  assign req         = i_io_lcd[8] != req_prev_q;
  assign req_word    = {i_io_lcd[9], i_io_lcd[7:0]};
  assign cnt_zero    = cnt_q == '0;
  assign unused_bits = ^i_io_lcd[30:10];
  // Clear display (0x01) and return home (0x02/0x03) need the long execution delay.
  assign long_cmd    = !cur_q[8] && (cur_q[7:2] == 6'd0) && (cur_q[1:0] != 2'd0);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req || pend_vld_q) state_d = StSetup;
      StSetup: if (cnt_zero) state_d = StPulse;
      StPulse: if (cnt_zero) state_d = StHold;
      StHold:  if (cnt_zero) state_d = StExec;
      StExec:  if (cnt_zero) state_d = pend_vld_q ? StSetup : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_lcd_en = state_q == StPulse;
    o_busy   = (state_q != StIdle) || pend_vld_q;
  end

  always_comb begin
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ack_d      = ack_q;
    ovf_d      = ovf_q;
    if (state_q != StIdle && !cnt_zero) cnt_d = cnt_q - 1'b1;
    unique case (state_q)
      StIdle: begin
        if (pend_vld_q) begin
          cur_d      = pend_q;
          pend_vld_d = 1'b0;
          cnt_d      = LdSetup;
        end else if (req) begin
          cur_d = req_word;
          cnt_d = LdSetup;
        end
      end
      StSetup: if (cnt_zero) cnt_d = LdPulse;
      StPulse: if (cnt_zero) cnt_d = LdHold;
      StHold:  if (cnt_zero) cnt_d = long_cmd ? LdExecLong : LdExec;
      StExec: begin
        if (cnt_zero) begin
          ack_d = ~ack_q;
          cnt_d = LdSetup;
          if (pend_vld_q) begin
            cur_d      = pend_q;
            pend_vld_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
    // Slot fullness is judged before this cycle's consumption, so a request arriving as the
    // slot drains is still dropped.
    if (req && !(state_q == StIdle && !pend_vld_q)) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        pend_d     = req_word;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    req_prev_q <= i_io_lcd[8];
    if (!i_reset) begin
      cnt_q      <= '0;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ack_q      <= 1'b0;
      ovf_q      <= 1'b0;
      on_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ack_q      <= ack_d;
      ovf_q      <= ovf_d;
      on_q       <= i_io_lcd[31];
    end
  end

  assign o_lcd_data = cur_q[7:0];
  assign o_lcd_rs   = cur_q[8];
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_on   = on_q;
  assign o_ack      = ack_q;
  assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: directed scenarios plus random toggles, checked every cycle against a
// transaction-timeline model (elapsed cycles since SETUP entry).
module tb_lcd_ctrl;

  localparam int unsigned TS  = 2;
  localparam int unsigned TP  = 3;
  localparam int unsigned TH  = 2;
  localparam int unsigned TE  = 5;
  localparam int unsigned TEL = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] io_lcd = 32'h0000_0100;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on, busy, ack, ovf;

  always #5 clk = ~clk;

  lcd_ctrl #(
    .T_SETUP    (TS),
    .T_PULSE    (TP),
    .T_HOLD     (TH),
    .T_EXEC     (TE),
    .T_EXEC_LONG(TEL),
    .CNT_W      (17)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .i_io_lcd  (io_lcd),
    .o_lcd_data(lcd_data),
    .o_lcd_rs  (lcd_rs),
    .o_lcd_rw  (lcd_rw),
    .o_lcd_en  (lcd_en),
    .o_lcd_on  (lcd_on),
    .o_busy    (busy),
    .o_ack     (ack),
    .o_ovf     (ovf)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit         m_active;
  int         m_t;
  logic [8:0] m_cur;
  logic [8:0] m_pend[$];
  bit         m_ack, m_ovf, m_prev, m_on;
  logic [31:0] w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int total_len(input logic [8:0] c);
    int ex;
    ex = (c[8] == 1'b0 && c[7:0] >= 8'd1 && c[7:0] <= 8'd3) ? TEL : TE;
    return TS + TP + TH + ex;
  endfunction

  task automatic model_edge(input logic [31:0] wi, input logic rst);
    bit req, full, was_idle, done;
    logic [8:0] word;
    if (!rst) begin
      m_active = 0;
      m_pend.delete();
      m_ack = 0;
      m_ovf = 0;
      m_cur = '0;
      m_prev = wi[8];
      m_on = 0;
      return;
    end
    req    = wi[8] != m_prev;
    m_prev = wi[8];
    m_on   = wi[31];
    word   = {wi[9], wi[7:0]};
    full     = m_pend.size() != 0;
    was_idle = !m_active;
    done     = m_active && (m_t == total_len(m_cur) - 1);
    if (m_active) begin
      m_t++;
      if (done) begin
        m_ack    = !m_ack;
        m_active = 0;
      end
    end
    if (full && (was_idle || done)) begin
      m_cur    = m_pend.pop_front();
      m_active = 1;
      m_t      = 0;
    end
    if (req) begin
      if (was_idle && !full) begin
        m_cur    = word;
        m_active = 1;
        m_t      = 0;
      end else if (full) begin
        m_ovf = 1;
      end else begin
        m_pend.push_back(word);
      end
    end
  endtask

  task automatic step(input logic [31:0] wi, input logic rst);
    logic [31:0] exp_v, got_v;
    bit en;
    @(negedge clk);
    io_lcd = wi;
    rst_n  = rst;
    model_edge(wi, rst);
    @(posedge clk);
    #1;
    en    = m_active && m_t >= TS && m_t < TS + TP;
    exp_v = {17'd0, m_on, m_ovf, m_ack, (m_active || m_pend.size() != 0), en, 1'b0, m_cur};
    got_v = {17'd0, lcd_on, ovf, ack, busy, lcd_en, lcd_rw, lcd_rs, lcd_data};
    check("outs", got_v, exp_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(w, 1'b1);
  endtask

  task automatic send(input logic rs, input logic [7:0] b);
    w[8]   = ~w[8];
    w[9]   = rs;
    w[7:0] = b;
    step(w, 1'b1);
  endtask

  // Counts edges after SETUP entry until o_ack flips; 0 if it never does within the bound.
  task automatic ack_latency(output int lat);
    logic a0;
    a0  = ack;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step(w, 1'b1);
      if (lat == 0 && ack != a0) lat = k;
    end
  endtask

  initial begin
    int lat;
    logic rs_r;
    logic [7:0] b;
    w = 32'h0000_0100;

    // Reset with request bit high, then release: nothing happens
    repeat (3) step(w, 1'b0);
    idle(6);
    check("idle_busy", {31'd0, busy}, 32'd0);

    w[31] = 1'b1;
    idle(2);

    // Data write 0x41
    send(1'b1, 8'h41);
    ack_latency(lat);
    check("ack_lat_data", lat, 32'd12);
    check("busy_fall", {31'd0, busy}, 32'd0);

    // Clear display: long delay
    send(1'b0, 8'h01);
    ack_latency(lat);
    check("ack_lat_long", lat, 32'd27);

    // Two back-to-back requests
    send(1'b0, 8'h30);
    send(1'b0, 8'h31);
    idle(40);
    check("ovf_two", {31'd0, ovf}, 32'd0);

    // Three rapid requests: third is dropped
    send(1'b0, 8'h30);
    send(1'b0, 8'h31);
    send(1'b0, 8'h32);
    idle(40);
    check("ovf_three", {31'd0, ovf}, 32'd1);

    // Reset during PULSE
    send(1'b1, 8'h55);
    idle(2);
    check("in_pulse", {31'd0, lcd_en}, 32'd1);
    step(w, 1'b0);
    check("en_after_rst", {31'd0, lcd_en}, 32'd0);
    idle(5);
    check("state_after_rst", {29'd0, busy, ack, ovf}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      w[30:10] = 21'($urandom);
      if ($urandom_range(0, 31) == 0) w[31] = ~w[31];
      if ($urandom_range(0, 7) == 0) begin
        w[8] = ~w[8];
        rs_r = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 3));
        else b = 8'($urandom);
        w[9]   = rs_r;
        w[7:0] = b;
      end
      step(w, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
